mem_byte_sequencer: RTL and testbench
=====================================

# mem_byte_sequencer

Bridges the CPU's 32-bit memory datapath (MAR address, MDR write data, IR/MDR read return) to the byte-wide 256-entry RAM port. It turns one byte, halfword or word request into 1, 2 or 4 sequential byte beats, in big-endian order, each beat handshaked with the RAM. It assembles read data, sign- or zero-extends it, and signals completion with a one-cycle MOC-style pulse. It sits directly downstream of the MAR/MDR registers and upstream of the RAM.

## Interface
- ADDR_W, 8, byte address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, CPU-side data width

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe, sampled only when req_ready=1
- req_ready  out  1  sequencer idle and able to accept a request
- req_rw  in  1  1=read, 0=write
- req_addr  in  ADDR_W  base byte address
- req_dt  in  2  size: 00 byte, 01 halfword, 10 word, 11 treated as word
- req_sign  in  1  reads only: 1 = sign-extend, 0 = zero-extend
- req_wdata  in  DATA_W  write data, right-justified
- rsp_valid  out  1  one-cycle completion pulse (MOC)
- rsp_rdata  out  DATA_W  extended read data, valid while rsp_valid=1
- rsp_fault  out  1  misaligned request; exists only under MEM_ALIGN_CHECK_EN
- mem_en  out  1  byte access strobe
- mem_we  out  1  1=write beat
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  8  beat write byte
- mem_rdata  in  8  beat read byte
- mem_ack  in  1  beat complete; may be asserted in the same cycle as mem_en

## Operation
- The FSM has three states: IDLE, BEAT, RESP.
- **IDLE.** req_ready=1. When req_valid=1, latch rw, addr, dt, sign and wdata. Set beats to 1, 2 or 4, set idx=0, clear the accumulator, and go to BEAT.
- **BEAT.** mem_en=1, mem_we=!rw, mem_addr=(addr+idx) mod 2^ADDR_W.
  - Write beat: mem_wdata = wdata byte (beats-1-idx), so the most significant byte goes to the lowest address.
  - Read beat: when mem_ack=1, acc <= {acc[23:0], mem_rdata}.
  - mem_ack=1 increments idx. On the last beat, go to RESP.
  - mem_ack=0 holds every mem_* output stable.
- **RESP.** rsp_valid=1 for exactly one cycle, then go to IDLE.
  - Reads: rsp_rdata = acc extended from 8, 16 or 32 bits according to dt and sign.
  - Writes: rsp_rdata=0.
- There is no response backpressure. A req_valid arriving outside IDLE is ignored, not queued.
- Reset values: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=0; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; acc=0, idx=0.
- An asynchronous clr during BEAT drops mem_en and mem_we immediately. A partially written word stays partially written.

## Timing
- Zero-wait RAM (mem_ack tied high): accept at cycle 0, beats at cycles 1..N, rsp_valid at cycle N+1. Byte takes 2 cycles, halfword 3, word 5.
- Each RAM wait cycle adds one cycle to the beat it stalls.
- req_ready deasserts the cycle after accept and reasserts the cycle after rsp_valid. The minimum request spacing is therefore N+2 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from req_* to mem_*.

## Configuration
- **MEM_ALIGN_CHECK_EN defined.**
  - A misaligned request goes IDLE→RESP with no memory beats. Misaligned means a halfword with addr[0]=1, or a word (dt 10/11) with addr[1:0]≠0.
  - In that RESP cycle rsp_fault=1 and rsp_rdata=0.
  - rsp_fault is 0 on every other response.
- **MEM_ALIGN_CHECK_EN undefined.**
  - The rsp_fault port is absent.
  - Misaligned requests perform normal beats, with the address wrapping (e.g. a word at 0xFE uses 0xFE, 0xFF, 0x00, 0x01).

## Structure
- Package mem_seq_pkg holds:
  - the DT_BYTE, DT_HALF and DT_WORD encodings;
  - the state enum IDLE/BEAT/RESP;
  - the function dt_beats(dt).
- One sub-module, mem_read_extender, is combinational. It takes acc, dt and sign and produces the extended 32-bit rsp_rdata.

## Test plan
- **Word write, zero-wait.** Write 0x11223344 to 0x10 → beats at 0x10..0x13 carry 0x11, 0x22, 0x33, 0x44; rsp_valid at cycle 5.
- **Signed byte read.** RAM[0x20]=0x85, sign=1 → rsp_rdata=0xFFFFFF85. The same read with sign=0 → 0x00000085.
- **Halfword read with wait states.** RAM[0x40..0x41]=0x80,0x01 with mem_ack delayed 2 cycles per beat → rsp_rdata=0xFFFF8001 (sign=1); rsp_valid at cycle 7; mem_addr held stable while stalled.
- **Reset mid-operation.** Drive clr low during beat 2 of a word write → mem_en falls in the same cycle, state returns to IDLE, req_ready=1. A following byte read completes normally.
- **Misaligned word at 0x02.**
  - With MEM_ALIGN_CHECK_EN: rsp_fault=1 at cycle 1 and no mem_en pulses.
  - Without it: 4 beats at 0x02..0x05.
- **Request during busy.** A second req_valid asserted during BEAT is ignored; exactly one rsp_valid results.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared encodings for the byte sequencer.
// Size codes, FSM state enum, and the size-to-beat-count helper.
package mem_seq_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of byte beats for a size code; code 11 behaves as a word.
    function automatic logic [2:0] dt_beats(input logic [1:0] dt);
        case (dt)
            DT_BYTE: dt_beats = 3'd1;
            DT_HALF: dt_beats = 3'd2;
            default: dt_beats = 3'd4;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] addr_lo);
        case (dt)
            DT_BYTE: is_misaligned = 1'b0;
            DT_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_read_extender.sv
// mem_read_extender: widens the assembled read accumulator to the CPU data
// width, sign- or zero-extending from 8, 16 or full width by size code.
module mem_read_extender
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [1:0]        dt_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] ext_o
);

    // Pick the live low bits of the accumulator and fill the rest.
    always_comb begin
        ext_o = acc_i;
        case (dt_i)
            DT_BYTE: ext_o = {{(DATA_W-8){sign_i & acc_i[7]}}, acc_i[7:0]};
            DT_HALF: ext_o = {{(DATA_W-16){sign_i & acc_i[15]}}, acc_i[15:0]};
            default: ext_o = acc_i;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits one byte/halfword/word CPU access into 1, 2 or 4
// big-endian byte beats on the RAM port and returns extended read data with a
// one-cycle completion pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned requests skip the
// RAM and complete immediately with rsp_fault=1.
//
// Handshakes: a request is taken on any rising edge where req_valid=1 and
// req_ready=1; a RAM beat completes on any rising edge where mem_en=1 and
// mem_ack=1, and all mem_* outputs stay constant until it does.
// rsp_valid is a pulse with no backpressure.
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_dt,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              rsp_fault,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          dt_q, dt_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          beats_q, beats_d;
    logic [2:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                fault_q, fault_d;

    logic                misalign_w;
    logic                last_beat_w;
    logic [2:0]          sel_full_w;
    logic [1:0]          byte_sel_w;
    logic [DATA_W-1:0]   ext_data_w;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_w = is_misaligned(req_dt, req_addr[1:0]);
`else
    assign misalign_w = 1'b0;
`endif

    assign last_beat_w = (idx_q == beats_q - 3'd1);
    // First beat carries the most significant live byte of the write data.
    assign sel_full_w  = beats_q - 3'd1 - idx_q;
    assign byte_sel_w  = sel_full_w[1:0];

    mem_read_extender #(.DATA_W(DATA_W)) u_ext (
        .acc_i  (acc_q),
        .dt_i   (dt_q),
        .sign_i (sign_q),
        .ext_o  (ext_data_w)
    );

    // State register; clr returns to IDLE at once, which also drops mem_en.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: accept in IDLE, step beats on ack, one RESP cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = misalign_w ? RESP : BEAT;
            BEAT:    if (mem_ack && last_beat_w) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the request, advance the beat index,
    // and shift returned bytes into the accumulator (big-endian assembly).
    always_comb begin
        rw_d    = rw_q;
        addr_d  = addr_q;
        dt_d    = dt_q;
        sign_d  = sign_q;
        wdata_d = wdata_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    dt_d    = req_dt;
                    sign_d  = req_sign;
                    wdata_d = req_wdata;
                    beats_d = dt_beats(req_dt);
                    idx_d   = 3'd0;
                    acc_d   = '0;
                    fault_d = misalign_w;
                end
            end
            BEAT: begin
                if (mem_ack) begin
                    idx_d = idx_q + 3'd1;
                    if (rw_q) acc_d = {acc_q[DATA_W-9:0], mem_rdata};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            dt_q    <= DT_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            beats_q <= 3'd0;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            dt_q    <= dt_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decoded from registered state only; idle values are zero.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        mem_en    = (state_q == BEAT);
        mem_we    = (state_q == BEAT) && !rw_q;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        rsp_rdata = '0;
        if (state_q == BEAT) begin
            mem_addr  = addr_q + ADDR_W'(idx_q);
            mem_wdata = wdata_q[{byte_sel_w, 3'b000} +: 8];
        end
        if ((state_q == RESP) && rw_q && !fault_q) rsp_rdata = ext_data_w;
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Fault flag only on the response of a rejected misaligned request.
    always_comb rsp_fault = (state_q == RESP) && fault_q;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: table of directed vectors, hand-written
// reset/busy sequences, and randomized requests against a byte-array model.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [1:0]  req_dt = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault_w;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_byte_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_dt    (req_dt),
        .req_sign  (req_sign),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef MEM_ALIGN_CHECK_EN
        .rsp_fault (rsp_fault_w),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state)
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign rsp_fault_w = 1'b0;
`endif

    // ---------------- RAM model ----------------
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    logic       ram_clear = 1'b0;
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;
    int         wait_cfg = 0;
    int         wait_ctr = 0;

    always_comb mem_ack = mem_en && (wait_ctr >= wait_cfg);
    always_comb mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (!mem_en || mem_ack) wait_ctr <= 0;
        else                    wait_ctr <= wait_ctr + 1;
    end

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (mem_en && mem_we && mem_ack) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- beat monitor ----------------
    logic [16:0] beat_q[$];
    logic [16:0] exp_q[$];
    logic        stall_seen = 1'b0;
    logic [16:0] stall_snap = '0;

    always @(posedge clk) begin
        if (stall_seen && mem_en) begin
            n_tests++;
            if ({mem_we, mem_addr, mem_wdata} !== stall_snap) begin
                n_fail++;
                $display("FAIL stall_hold: got %h expected %h", {mem_we, mem_addr, mem_wdata}, stall_snap);
            end
        end
        stall_seen = mem_en && !mem_ack;
        stall_snap = {mem_we, mem_addr, mem_wdata};
        if (mem_en && mem_ack)
            beat_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one request from IDLE and wait for its response pulse.
    task automatic run_req(input logic rw, input logic [7:0] a, input logic [1:0] dt,
                           input logic sg, input logic [31:0] wd,
                           output logic [31:0] rd, output logic flt, output int lat);
        lat = -1; rd = '0; flt = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_dt = dt;
        req_sign = sg; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; flt = rsp_fault_w;
                break;
            end
        end
    endtask

    function automatic logic model_misaligned(input logic [7:0] a, input logic [1:0] dt);
`ifdef MEM_ALIGN_CHECK_EN
        return (dt == 2'b01 && a[0]) || (dt[1] && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: byte list in big-endian order, arithmetic extension.
    task automatic check_req(input string tag, input logic rw, input logic [7:0] a,
                             input logic [1:0] dt, input logic sg, input logic [31:0] wd,
                             input logic use_tab, input logic [31:0] tab_rd, input int tab_lat);
        int          n;
        longint      v;
        longint      mask;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_flt;
        logic [7:0]  ad;
        logic [7:0]  b;
        logic [31:0] rd;
        logic        flt;
        int          lat;
        logic [16:0] got;
        logic [16:0] want;

        n = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
        exp_q.delete();
        beat_q.delete();
        v = 0;
        if (model_misaligned(a, dt)) begin
            exp_rd = 32'h0; exp_lat = 1; exp_flt = 1'b1;
        end else begin
            exp_flt = 1'b0;
            for (int i = 0; i < n; i++) begin
                ad = a + 8'(i);
                if (rw) begin
                    b = ref_mem[ad];
                    v = (v << 8) | longint'(b);
                    exp_q.push_back({1'b0, ad, b});
                end else begin
                    b = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
                    ref_mem[ad] = b;
                    exp_q.push_back({1'b1, ad, b});
                end
            end
            mask = (64'sd1 <<< (8 * n)) - 1;
            if (rw && sg && v[8*n-1]) v = v | ~mask;
            exp_rd = rw ? v[31:0] : 32'h0;
            exp_lat = n * (wait_cfg + 1) + 1;
        end

        run_req(rw, a, dt, sg, wd, rd, flt, lat);

        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_fault"}, {31'h0, flt}, {31'h0, exp_flt});
        if (use_tab && !exp_flt) begin
            chk({tag, "_tab_rdata"}, rd, tab_rd);
            chk({tag, "_tab_latency"}, lat, tab_lat);
        end
        chk({tag, "_beats"}, beat_q.size(), exp_q.size());
        while (exp_q.size() > 0 && beat_q.size() > 0) begin
            got = beat_q.pop_front();
            want = exp_q.pop_front();
            chk({tag, "_beat"}, {15'h0, got}, {15'h0, want});
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [1:0]  dt;
        logic        sg;
        logic [31:0] wd;
        int          w;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tab [14];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          rsp_cnt;

        tab[0]  = '{1'b0, 8'h10, 2'b10, 1'b0, 32'h11223344, 0, 32'h00000000, 5};
        tab[1]  = '{1'b1, 8'h10, 2'b10, 1'b0, 32'h0,        0, 32'h11223344, 5};
        tab[2]  = '{1'b1, 8'h20, 2'b00, 1'b1, 32'h0,        0, 32'hFFFFFF85, 2};
        tab[3]  = '{1'b1, 8'h20, 2'b00, 1'b0, 32'h0,        0, 32'h00000085, 2};
        tab[4]  = '{1'b1, 8'h40, 2'b01, 1'b1, 32'h0,        2, 32'hFFFF8001, 7};
        tab[5]  = '{1'b1, 8'h40, 2'b01, 1'b0, 32'h0,        0, 32'h00008001, 3};
        tab[6]  = '{1'b0, 8'h02, 2'b10, 1'b0, 32'hDEADBEEF, 0, 32'h00000000, 5};
        tab[7]  = '{1'b1, 8'h02, 2'b11, 1'b0, 32'h0,        0, 32'hDEADBEEF, 5};
        tab[8]  = '{1'b1, 8'hFE, 2'b10, 1'b1, 32'h0,        0, 32'hA1B2C3D4, 5};
        tab[9]  = '{1'b0, 8'h30, 2'b00, 1'b0, 32'hABCDEF5A, 0, 32'h00000000, 2};
        tab[10] = '{1'b1, 8'h30, 2'b01, 1'b1, 32'h0,        1, 32'h00005A00, 5};
        tab[11] = '{1'b0, 8'h32, 2'b01, 1'b0, 32'h1234F00D, 0, 32'h00000000, 3};
        tab[12] = '{1'b1, 8'h30, 2'b10, 1'b0, 32'h0,        0, 32'h5A00F00D, 5};
        tab[13] = '{1'b1, 8'h32, 2'b01, 1'b1, 32'h0,        0, 32'hFFFFF00D, 3};

        // Reset and RAM clear
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        clr = 1'b0; ram_clear = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_fault", {31'h0, rsp_fault_w}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        chk("rst_state", {30'h0, dbg_state}, 32'h0);
        clr = 1'b1; ram_clear = 1'b0;

        poke(8'h20, 8'h85);
        poke(8'h40, 8'h80);
        poke(8'h41, 8'h01);
        poke(8'hFE, 8'hA1);
        poke(8'hFF, 8'hB2);
        poke(8'h00, 8'hC3);
        poke(8'h01, 8'hD4);

        for (int r = 0; r < 14; r++) begin
            wait_cfg = tab[r].w;
            check_req($sformatf("tab%0d", r), tab[r].rw, tab[r].addr, tab[r].dt, tab[r].sg,
                      tab[r].wd, 1'b1, tab[r].exp_rd, tab[r].exp_lat);
        end

        // Reset during the second beat of a word write
        wait_cfg = 0;
        poke(8'h81, 8'h5A);
        beat_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h80; req_dt = 2'b10;
        req_sign = 1'b0; req_wdata = 32'hCAFEBABE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst_pre_mem_en", {31'h0, mem_en}, 32'h1);
        chk("midrst_pre_addr", {24'h0, mem_addr}, 32'h81);
        clr = 1'b0;
        #1;
        chk("midrst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        clr = 1'b1;
        chk("midrst_ram80", {24'h0, ram[8'h80]}, 32'hCA);
        chk("midrst_ram81", {24'h0, ram[8'h81]}, 32'h5A);
        ref_mem[8'h80] = 8'hCA;
        check_req("after_rst", 1'b1, 8'h20, 2'b00, 1'b0, 32'h0, 1'b1, 32'h00000085, 2);

        // Second request while busy must be dropped
        wait_cfg = 1;
        beat_q.delete();
        rsp_cnt = 0;
        rd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h10; req_dt = 2'b10;
        req_sign = 1'b0; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_addr = 8'h20; req_dt = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 4) req_valid = 1'b0;
            if (rsp_valid) begin
                rsp_cnt++;
                rd = rsp_rdata;
            end
        end
        req_valid = 1'b0;
        chk("busy_rsp_count", rsp_cnt, 1);
        chk("busy_rdata", rd, 32'h11223344);
        chk("busy_beats", beat_q.size(), 4);

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            wait_cfg = $urandom_range(0, 2);
            check_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                      1'b0, 32'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
